// File: rtl/mmio_stream_hub_pkg.sv
// Register map and shared constants for the multi-channel MMIO byte-stream hub.
// Pure definitions: no latency or backpressure of its own.
package mmio_stream_hub_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    localparam logic [31:0] TX_AVAIL_OFF = 32'h00;
    localparam logic [31:0] TX_DATA_OFF  = 32'h04;
    localparam logic [31:0] RX_AVAIL_OFF = 32'h08;
    localparam logic [31:0] RX_DATA_OFF  = 32'h0C;
    localparam logic [31:0] STATUS_OFF   = 32'h10;

    localparam int STAT_TX_OVF = 0;
    localparam int STAT_RX_OVF = 1;

endpackage

// File: rtl/mmio_stream_hub_sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through head, head reads 0 when empty.
// Push lands next edge; push while full is accepted only alongside a pop, pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the same-cycle push needs, so full does not block it.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_stream_hub.sv
// Multi-channel memory-mapped byte I/O: per channel a TX FIFO drained by valid/ready and an RX FIFO fed by strobes.
// Reads return one cycle after en; TX stalls on tx_ready, RX never stalls and drops on full (sticky W1C flags).
module mmio_stream_hub
    import mmio_stream_hub_pkg::*;
#(
    parameter int          CHANNELS       = 2,
    parameter int          TX_DEPTH       = 256,
    parameter int          RX_DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int          CH_STRIDE_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [31:0]           addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  hit,
    output logic [CHANNELS-1:0]   tx_valid,
    output logic [8*CHANNELS-1:0] tx_data,
    input  logic [CHANNELS-1:0]   tx_ready,
    input  logic [CHANNELS-1:0]   rx_strobe,
    input  logic [8*CHANNELS-1:0] rx_data,
    output logic [CHANNELS-1:0]   tx_busy
);
    localparam int          TXC_W    = $clog2(TX_DEPTH) + 1;
    localparam int          RXC_W    = $clog2(RX_DEPTH) + 1;
    localparam logic [31:0] SPAN     = 32'(CHANNELS) << CH_STRIDE_LOG2;
    localparam logic [31:0] OFF_MASK = (32'd1 << CH_STRIDE_LOG2) - 32'd1;

    logic [31:0] rel;
    logic [31:0] ch_idx;
    logic [31:0] off;
    logic        rd_acc;
    logic        wr_acc;
    logic [31:0] rdata;
    logic [23:0] din_unused;

    logic [TXC_W-1:0]    tx_count [CHANNELS];
    logic [RXC_W-1:0]    rx_count [CHANNELS];
    logic [7:0]          rx_head  [CHANNELS];
    logic [CHANNELS-1:0] tx_full, tx_empty, rx_full, rx_empty_unused;
    logic [CHANNELS-1:0] tx_push, tx_pop, rx_pop;
    logic [CHANNELS-1:0] tx_ovf, rx_ovf;
    logic [CHANNELS-1:0] tx_ovf_set, rx_ovf_set, tx_ovf_clr, rx_ovf_clr;

    // Unsigned wrap makes addresses below BASE_ADDR fall outside SPAN too.
    assign rel        = addr - BASE_ADDR;
    assign ch_idx     = rel >> CH_STRIDE_LOG2;
    assign off        = rel & OFF_MASK;
    assign hit        = (rel < SPAN) && (addr[1:0] == 2'b00);
    assign rd_acc     = en && hit && (we == 4'b0000);
    assign wr_acc     = en && hit && we[0];
    assign din_unused = din[31:8];
    assign tx_busy    = tx_valid;

    for (genvar c = 0; c < CHANNELS; c++) begin : gen_ch
        logic sel;
        assign sel = hit && (ch_idx == 32'(c));

        assign tx_push[c]  = wr_acc && sel && (off == TX_DATA_OFF);
        assign tx_valid[c] = !tx_empty[c];
        assign tx_pop[c]   = tx_valid[c] && tx_ready[c];
        assign rx_pop[c]   = rd_acc && sel && (off == RX_DATA_OFF);

        assign tx_ovf_set[c] = tx_push[c] && tx_full[c] && !tx_pop[c];
        assign rx_ovf_set[c] = rx_strobe[c] && rx_full[c] && !rx_pop[c];
        assign tx_ovf_clr[c] = wr_acc && sel && (off == STATUS_OFF) && din[STAT_TX_OVF];
        assign rx_ovf_clr[c] = wr_acc && sel && (off == STATUS_OFF) && din[STAT_RX_OVF];

        sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (tx_push[c]),
            .pop   (tx_pop[c]),
            .din   (din[7:0]),
            .dout  (tx_data[8*c +: 8]),
            .count (tx_count[c]),
            .full  (tx_full[c]),
            .empty (tx_empty[c])
        );

        sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (rx_strobe[c]),
            .pop   (rx_pop[c]),
            .din   (rx_data[8*c +: 8]),
            .dout  (rx_head[c]),
            .count (rx_count[c]),
            .full  (rx_full[c]),
            .empty (rx_empty_unused[c])
        );
    end

    // Set wins over a same-cycle W1C clear so no overflow event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf <= '0;
            rx_ovf <= '0;
        end else begin
            tx_ovf <= (tx_ovf & ~tx_ovf_clr) | tx_ovf_set;
            rx_ovf <= (rx_ovf & ~rx_ovf_clr) | rx_ovf_set;
        end
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == 32'(c)) begin
                case (off)
                    TX_AVAIL_OFF: rdata = 32'(TX_DEPTH) - 32'(tx_count[c]);
                    RX_AVAIL_OFF: rdata = 32'(rx_count[c]);
                    RX_DATA_OFF:  rdata = {24'b0, rx_head[c]};
                    STATUS_OFF: begin
                        rdata[STAT_TX_OVF] = tx_ovf[c];
                        rdata[STAT_RX_OVF] = rx_ovf[c];
                    end
                    default:      rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) dout <= '0;
        else       dout <= rd_acc ? rdata : '0;
    end

endmodule

// File: tb/tb_mmio_stream_hub.sv
// Scoreboard bench for mmio_stream_hub: register reads and TX stream bytes are checked against queued expectations.
module tb_mmio_stream_hub;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  we = 4'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        hit;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [1:0]  tx_ready = 2'b00;
    logic [1:0]  rx_strobe = 2'b00;
    logic [15:0] rx_data = '0;
    logic [1:0]  tx_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  txq0 [$];
    logic [7:0]  txq1 [$];
    logic [7:0]  rxq0 [$];
    logic        rd_pend = 1'b0;

    mmio_stream_hub #(
        .CHANNELS(2), .TX_DEPTH(256), .RX_DEPTH(16), .BASE_ADDR(BASE), .CH_STRIDE_LOG2(5)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .din(din), .dout(dout),
        .hit(hit), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_strobe(rx_strobe), .rx_data(rx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ad(input int ch, input int off);
        return BASE + 32'(ch * 32) + 32'(off);
    endfunction

    task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        en = 1'b1; we = w; addr = a; din = d;
        @(negedge clk);
        en = 1'b0; we = 4'b0; din = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(a, 4'b0001, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        access(a, 4'b0000, '0);
    endtask

    task automatic tx_seen(input int c, input logic [7:0] got);
        if (c == 0) begin
            if (txq0.size() == 0) check("tx0_unexpected", {24'b0, got}, 32'hFFFF_FFFF);
            else check("tx0_byte", {24'b0, got}, {24'b0, txq0.pop_front()});
        end else begin
            if (txq1.size() == 0) check("tx1_unexpected", {24'b0, got}, 32'hFFFF_FFFF);
            else check("tx1_byte", {24'b0, got}, {24'b0, txq1.pop_front()});
        end
    endtask

    // Sample one time unit before each rising edge: inputs and outputs are both settled.
    always @(negedge clk) begin
        #4;
        if (rd_pend) begin
            if (exp_q.size() == 0) check("rd_unexpected", dout, 32'hDEAD_BEEF);
            else check("rd_dout", dout, exp_q.pop_front());
        end
        rd_pend = en && (we == 4'b0000) && !reset;
        if (!reset) begin
            for (int c = 0; c < 2; c++)
                if (tx_valid[c] && tx_ready[c]) tx_seen(c, tx_data[8*c +: 8]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_tx_valid", {30'b0, tx_valid}, 0);
        check("rst_tx_data", {16'b0, tx_data}, 0);
        reset = 1'b0;

        rd(ad(0, 'h00), 256);
        rd(ad(0, 'h08), 0);
        rd(ad(0, 'h10), 0);
        check("idle_tx_valid", {30'b0, tx_valid}, 0);

        // Two bytes on channel 1 held back, then drained.
        txq1.push_back(8'h41); wr(ad(1, 'h04), 32'h0000_0041);
        txq1.push_back(8'h42); wr(ad(1, 'h04), 32'hFFFF_FF42);
        check("ch1_tx_valid", {30'b0, tx_valid}, 32'h2);
        check("ch1_tx_busy", {30'b0, tx_busy}, 32'h2);
        check("ch1_tx_head", {24'b0, tx_data[15:8]}, 32'h41);
        rd(ad(1, 'h00), 254);
        tx_ready = 2'b10;
        repeat (2) @(negedge clk);
        tx_ready = 2'b00;
        check("ch1_tx_drained", {30'b0, tx_valid}, 0);
        check("ch1_txq_empty", txq1.size(), 0);
        access(ad(1, 'h04), 4'b0010, 32'h55);
        rd(ad(1, 'h00), 256);

        // RX overflow on channel 0.
        for (int i = 0; i < 17; i++) begin
            rx_strobe = 2'b01; rx_data = {8'h00, 8'(i)};
            if (rxq0.size() < 16) rxq0.push_back(8'(i));
            @(negedge clk);
        end
        rx_strobe = 2'b00;
        rd(ad(0, 'h08), 16);
        rd(ad(0, 'h10), 2);
        rd(ad(1, 'h10), 0);
        for (int i = 0; i < 16; i++) rd(ad(0, 'h0C), {24'b0, rxq0.pop_front()});
        rd(ad(0, 'h0C), 0);
        rd(ad(0, 'h08), 0);
        wr(ad(0, 'h10), 32'h2);
        rd(ad(0, 'h10), 0);

        // Full RX FIFO with a same-cycle CPU pop and strobe: no overflow.
        for (int i = 0; i < 16; i++) begin
            rx_strobe = 2'b01; rx_data = {8'h00, 8'(8'h80 + i)};
            rxq0.push_back(8'(8'h80 + i));
            @(negedge clk);
        end
        rx_strobe = 2'b01; rx_data = 16'h0099;
        rxq0.push_back(8'h99);
        rd(ad(0, 'h0C), {24'b0, rxq0.pop_front()});
        rx_strobe = 2'b00;
        rd(ad(0, 'h10), 0);
        rd(ad(0, 'h08), 16);
        for (int i = 0; i < 16; i++) rd(ad(0, 'h0C), {24'b0, rxq0.pop_front()});

        // Fill channel 0 TX, overflow, then a write that coincides with a pop.
        for (int i = 0; i < 256; i++) begin
            txq0.push_back(8'(i));
            wr(ad(0, 'h04), 32'(i));
        end
        rd(ad(0, 'h00), 0);
        wr(ad(0, 'h04), 32'hFF);
        rd(ad(0, 'h10), 1);
        wr(ad(0, 'h10), 32'h1);
        rd(ad(0, 'h10), 0);
        tx_ready = 2'b01;
        txq0.push_back(8'hEE);
        wr(ad(0, 'h04), 32'hEE);
        tx_ready = 2'b00;
        rd(ad(0, 'h10), 0);
        rd(ad(0, 'h00), 0);

        // Address decode edges.
        addr = 32'h8000_0100; #1; check("hit_past_end", {31'b0, hit}, 0);
        addr = 32'h8000_003C; #1; check("hit_last_word", {31'b0, hit}, 1);
        addr = 32'h8000_0001; #1; check("hit_unaligned", {31'b0, hit}, 0);
        addr = 32'h7FFF_FFFC; #1; check("hit_below", {31'b0, hit}, 0);
        @(negedge clk);
        rd(32'h8000_0100, 0);

        // Drain part of channel 0 and reset in the middle.
        tx_ready = 2'b01;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        txq0.delete();
        @(negedge clk);
        check("mid_rst_tx_valid", {30'b0, tx_valid}, 0);
        check("mid_rst_tx_data", {16'b0, tx_data}, 0);
        reset = 1'b0;
        tx_ready = 2'b00;
        rd(ad(0, 'h00), 256);
        rd(ad(1, 'h00), 256);
        rd(ad(0, 'h08), 0);
        rd(ad(0, 'h10), 0);

        repeat (3) @(negedge clk);
        check("rd_sb_drained", exp_q.size(), 0);
        check("txq0_drained", txq0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
